// File: rtl/neurosync_pkg.sv
// Shared types and constants for the NeuroSync host-side serial receiver.
package neurosync_pkg;

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StStart  = 4'd1,
    StData   = 4'd2,
    StParity = 4'd3,
    StStop1  = 4'd4,
    StStop2  = 4'd5
  } rx_state_t;

  localparam int unsigned DATA_BITS = 7;
  localparam int unsigned STOP_BITS = 2;

  // Characters the host decoder looks for in the controller stream.
  localparam logic [DATA_BITS-1:0] ASCII_NUL     = 7'h00;
  localparam logic [DATA_BITS-1:0] ASCII_LF      = 7'h0A;
  localparam logic [DATA_BITS-1:0] ASCII_CR      = 7'h0D;
  localparam logic [DATA_BITS-1:0] ASCII_ZERO    = 7'h30;
  localparam logic [DATA_BITS-1:0] ASCII_UPPER_A = 7'h41;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/neurosync_rx_fifo.sv
// Small synchronous FIFO; Depth must be a power of two, at least 2.
module neurosync_rx_fifo #(
  parameter int unsigned Width = 7,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AddrW+1)'(Depth));
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_pop  = pop_i && !empty_o;
  // A full FIFO still takes a write when the head is leaving the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AddrW+1)'(do_push) - (AddrW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/neurosync_serial_rx.sv
// 7E2 asynchronous receiver for the NeuroSync controller line, with a
// character FIFO and valid/ready output.
module neurosync_serial_rx
  import neurosync_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 serial,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] dado,
  output logic                 valid,
  output logic                 erro_paridade,
  output logic                 erro_stop,
  output logic                 overflow,
  output logic [3:0]           db_estado
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic                 sync_q, s, s_prev;
  rx_state_t            state_q;
  logic [CntW-1:0]      cnt_q;
  logic [2:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, stop_err_q;
  logic                 tick, stop_bad, push, pop, full, empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= 1'b1;
      s      <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync_q <= serial;
      s      <= sync_q;
      s_prev <= s;
    end
  end

  always_comb begin
    tick     = (state_q == StStart) ? (cnt_q == HalfLast) : (cnt_q == BitLast);
    stop_bad = stop_err_q || !s;
    push     = (state_q == StStop2) && tick && !stop_bad && !par_err_q;
    pop      = valid && ready;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bit_q         <= '0;
      shift_q       <= '0;
      par_err_q     <= 1'b0;
      stop_err_q    <= 1'b0;
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      erro_paridade <= 1'b0;
      erro_stop     <= 1'b0;
      overflow      <= push && full && !pop;
      cnt_q         <= cnt_q + 1'b1;
      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          bit_q <= '0;
          if (s_prev && !s) state_q <= StStart;
        end
        StStart: if (tick) begin
          cnt_q   <= '0;
          state_q <= s ? StIdle : StData;
        end
        StData: if (tick) begin
          cnt_q   <= '0;
          shift_q <= {s, shift_q[DATA_BITS-1:1]};
          bit_q   <= bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS - 1)) state_q <= StParity;
        end
        StParity: if (tick) begin
          cnt_q     <= '0;
          par_err_q <= even_parity(shift_q) ^ s;
          state_q   <= StStop1;
        end
        StStop1: if (tick) begin
          cnt_q      <= '0;
          stop_err_q <= !s;
          state_q    <= StStop2;
        end
        StStop2: if (tick) begin
          // Stop error wins so that a bad frame raises exactly one pulse.
          erro_stop     <= stop_bad;
          erro_paridade <= !stop_bad && par_err_q;
          state_q       <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  neurosync_rx_fifo #(
    .Width(DATA_BITS),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clock),
    .rst_ni (reset),
    .push_i (push),
    .wdata_i(shift_q),
    .pop_i  (pop),
    .rdata_o(dado),
    .full_o (full),
    .empty_o(empty)
  );

  assign valid     = !empty;
  assign db_estado = state_q;

endmodule

// File: tb/tb_neurosync_serial_rx.sv
// Directed bench for neurosync_serial_rx at 16 clocks per bit.
module tb_neurosync_serial_rx;

  localparam int unsigned Cpb = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial = 1'b1;
  logic       ready = 1'b0;
  logic [6:0] dado;
  logic       valid, erro_paridade, erro_stop, overflow;
  logic [3:0] db_estado;

  int n_cmp = 0, n_err = 0;
  int cyc = 0, fall_cyc = 0, rise_cyc = -1;
  int n_perr = 0, n_serr = 0, n_ovf = 0;
  int p0, s0, o0;
  logic valid_d = 1'b0;
  logic collect = 1'b0;
  logic [6:0] rx_q [$];

  neurosync_serial_rx #(
    .CLKS_PER_BIT(Cpb),
    .FIFO_DEPTH  (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .serial       (serial),
    .ready        (ready),
    .dado         (dado),
    .valid        (valid),
    .erro_paridade(erro_paridade),
    .erro_stop    (erro_stop),
    .overflow     (overflow),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid && !valid_d) rise_cyc = cyc;
    valid_d = valid;
    if (erro_paridade) n_perr++;
    if (erro_stop) n_serr++;
    if (overflow) n_ovf++;
    if (collect && valid && ready) rx_q.push_back(dado);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; frame bits go out LSB first: start, data, parity, stop1, stop2.
  task automatic send_frame(input logic [6:0] data, input logic par, input logic stop2,
                            input int nbits);
    logic [10:0] frame;
    frame = {stop2, 1'b1, par, data, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < nbits; i++) begin
      serial = frame[i];
      repeat (Cpb) @(negedge clock);
    end
    serial = 1'b1;
  endtask

  task automatic pop_one();
    ready = 1'b1;
    @(negedge clock);
    ready = 1'b0;
  endtask

  task automatic snap();
    p0 = n_perr;
    s0 = n_serr;
    o0 = n_ovf;
  endtask

  initial begin
    logic [6:0] ovf_data [5];
    logic       ovf_par  [5];
    logic [6:0] bb_data  [3];
    ovf_data = '{7'h30, 7'h31, 7'h32, 7'h33, 7'h34};
    ovf_par  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bb_data  = '{7'h48, 7'h69, 7'h21};

    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("rst_dado", dado, 0);
    check_eq("rst_valid", valid, 0);
    check_eq("rst_perr", erro_paridade, 0);
    check_eq("rst_serr", erro_stop, 0);
    check_eq("rst_ovf", overflow, 0);
    check_eq("rst_state", db_estado, 0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // 'A', good frame; valid rises 171 cycles after the pin falls.
    snap();
    send_frame(7'h41, 1'b0, 1'b1, 11);
    repeat (4) @(negedge clock);
    check_eq("a_latency", rise_cyc - fall_cyc, 171);
    check_eq("a_valid", valid, 1);
    check_eq("a_dado", dado, 7'h41);
    check_eq("a_perr", n_perr - p0, 0);
    pop_one();
    check_eq("a_pop_valid", valid, 0);

    // '7' with parity forced wrong.
    snap();
    send_frame(7'h37, 1'b0, 1'b1, 11);
    repeat (4) @(negedge clock);
    check_eq("par_pulse", n_perr - p0, 1);
    check_eq("par_serr", n_serr - s0, 0);
    check_eq("par_valid", valid, 0);

    // STOP2 low: stop error only, even though parity is fine.
    snap();
    send_frame(7'h41, 1'b0, 1'b0, 11);
    repeat (20) @(negedge clock);
    check_eq("stop_pulse", n_serr - s0, 1);
    check_eq("stop_perr", n_perr - p0, 0);
    check_eq("stop_valid", valid, 0);

    // 6-cycle glitch.
    snap();
    serial = 1'b0;
    repeat (5) @(negedge clock);
    check_eq("glitch_start", db_estado, 1);
    @(negedge clock);
    serial = 1'b1;
    repeat (20) @(negedge clock);
    check_eq("glitch_idle", db_estado, 0);
    check_eq("glitch_pulses", (n_perr - p0) + (n_serr - s0) + (n_ovf - o0), 0);
    check_eq("glitch_valid", valid, 0);

    // Five back-to-back frames with no consumer: the fifth overflows.
    snap();
    for (int i = 0; i < 5; i++) send_frame(ovf_data[i], ovf_par[i], 1'b1, 11);
    repeat (4) @(negedge clock);
    check_eq("ovf_pulse", n_ovf - o0, 1);
    check_eq("ovf_errs", (n_perr - p0) + (n_serr - s0), 0);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("ovf_valid%0d", i), valid, 1);
      check_eq($sformatf("ovf_dado%0d", i), dado, 7'h30 + 7'(i));
      pop_one();
    end
    check_eq("ovf_drained", valid, 0);

    // Reset in the middle of a frame, with a character already waiting.
    send_frame(7'h33, 1'b0, 1'b1, 11);
    repeat (4) @(negedge clock);
    check_eq("pre_rst_valid", valid, 1);
    snap();
    send_frame(7'h55, 1'b0, 1'b1, 4);
    serial = 1'b0;
    check_eq("mid_state", db_estado, 2);
    reset = 1'b0;
    serial = 1'b1;
    #1;
    check_eq("mid_rst_valid", valid, 0);
    check_eq("mid_rst_dado", dado, 0);
    check_eq("mid_rst_state", db_estado, 0);
    check_eq("mid_rst_pulses", {29'd0, erro_paridade, erro_stop, overflow}, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    send_frame(7'h2A, 1'b1, 1'b1, 11);
    repeat (4) @(negedge clock);
    check_eq("post_rst_valid", valid, 1);
    check_eq("post_rst_dado", dado, 7'h2A);
    check_eq("post_rst_pulses", (n_perr - p0) + (n_serr - s0) + (n_ovf - o0), 0);
    pop_one();
    check_eq("post_rst_pop", valid, 0);

    // Full-rate stream with the consumer always ready.
    snap();
    rx_q.delete();
    collect = 1'b1;
    ready = 1'b1;
    for (int i = 0; i < 3; i++) send_frame(bb_data[i], 1'b0, 1'b1, 11);
    repeat (4) @(negedge clock);
    ready = 1'b0;
    collect = 1'b0;
    check_eq("bb_count", rx_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < rx_q.size()) check_eq($sformatf("bb_char%0d", i), rx_q[i], bb_data[i]);
      else check_eq($sformatf("bb_char%0d", i), 32'hFFFF_FFFF, bb_data[i]);
    end
    check_eq("bb_ovf", n_ovf - o0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/neurosync_serial_rx.md
# neurosync_serial_rx

Host-side receiver for the NeuroSync game controller's `serial` line. It deserialises the 7E2 asynchronous frames the controller transmits: 115200 baud, 7 data bits LSB first, even parity, 2 stop bits. Validated characters are buffered in a 4-deep FIFO and presented to a consumer over a valid/ready handshake. It sits on the PC/bridge FPGA, or in the loopback test harness, at the far end of the controller's `serial` output.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200); must be ≥ 8.
- `FIFO_DEPTH`, 4: character buffer entries; power of two.

Ports:
- `clock`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: asynchronous, active-low; `reset`=0 clears all state.
- `serial`  in  1: asynchronous line, idle high.
- `ready`  in  1: consumer accepts `dado` this cycle.
- `dado`  out  7: head-of-FIFO character.
- `valid`  out  1: FIFO non-empty; `dado` is meaningful.
- `erro_paridade`  out  1: one-cycle pulse; the frame was discarded because of a parity mismatch.
- `erro_stop`  out  1: one-cycle pulse; the frame was discarded because a stop bit sampled 0.
- `overflow`  out  1: one-cycle pulse; a good character was dropped because the FIFO was full.
- `db_estado`  out  4: current receive-FSM state, for debug.

## Operation
- `serial` passes through a 2-flop synchroniser, reset to 1. The FSM uses only the synchronised value `s`.
- FSM states: IDLE(0), START(1), DATA(2), PARITY(3), STOP1(4), STOP2(5).
  - IDLE: a falling edge on `s` (previous 1, current 0) → START; the bit counter and the cycle counter clear.
  - START: at cycle count `CLKS_PER_BIT/2 - 1`, sample `s`.
    - `s`=1 → glitch; go to IDLE, no error.
    - `s`=0 → DATA; the cycle counter restarts.
  - DATA: sample every `CLKS_PER_BIT` cycles into a shift register, LSB first. After 7 samples → PARITY.
  - PARITY: sample the parity bit. The frame is good only if XOR(data, parity) = 0.
  - STOP1, STOP2: sample `s` after a further `CLKS_PER_BIT` cycles each. Any 0 → frame error.
- End of frame, on the STOP2 sample cycle:
  - Stop error → `erro_stop` pulse; nothing written. This takes priority over a parity error, so only one pulse is issued.
  - Else parity error → `erro_paridade` pulse; nothing written.
  - Else push the character into the FIFO.
  - In every case the FSM returns to IDLE, so a new start edge is accepted in the remaining half of the stop bit.
- FIFO:
  - `valid` = not empty; `dado` = head entry.
  - Pop when `valid && ready`.
  - Push while full with no pop in the same cycle → char dropped, `overflow` pulse.
  - Push and pop in the same cycle while full → both occur; count stays at `FIFO_DEPTH`.
  - Pop while empty is ignored.
- Reset mid-frame aborts the frame: FSM to IDLE, FIFO emptied, no pulses.

## Timing
- Reset values: `dado`=0, `valid`=0, `erro_paridade`=0, `erro_stop`=0, `overflow`=0, `db_estado`=0, synchroniser flops=1.
- Start edge seen by the FSM 2 cycles after the pin falls (synchroniser).
- Sample points, counted from the detected edge:
  - START check at `CLKS_PER_BIT/2` cycles.
  - Data bit *i* at `CLKS_PER_BIT/2 + (i+1)·CLKS_PER_BIT`.
  - Parity at +8·`CLKS_PER_BIT`, STOP1 at +9·`CLKS_PER_BIT`, STOP2 at +10·`CLKS_PER_BIT`.
- Outputs after the STOP2 sample cycle:
  - `valid` rises, with `dado` stable, exactly 1 cycle later.
  - Error and overflow pulses appear in that same following cycle, registered.
- `dado` changes only on a pop or on the first push into an empty FIFO.
- Throughput: back-to-back frames at full baud with no loss while the consumer keeps `ready`=1.

## Structure
- Shared package `neurosync_pkg`:
  - the `rx_state_t` enum (encodings as above);
  - the `DATA_BITS`=7 and `STOP_BITS`=2 constants;
  - ASCII constants used by the host decoder.
- Sub-module `neurosync_rx_fifo`: synchronous FIFO (push/pop/full/empty/count) parameterised by width and depth.
- The synchroniser, counters, FSM and parity check stay in the top module.

## Test plan
All scenarios use `CLKS_PER_BIT`=16.
- Send 'A' (0x41, parity 0, stops 11) → `valid` 1 cycle after STOP2 sample, `dado`=0x41; `ready`=1 for one cycle → `valid`=0.
- Send '7' (0x37) with parity forced to 0 → `erro_paridade` pulse of exactly 1 cycle, `valid` stays 0.
- Send 0x41 with STOP2 forced to 0 → `erro_stop` pulse; no push.
- 6-cycle low glitch on an idle line → FSM returns to IDLE with no pulses, `db_estado` back to 0.
- `ready`=0, send 0x30–0x34 → FIFO holds 0x30–0x33, `overflow` pulses on 0x34; popping yields 0x30, 0x31, 0x32, 0x33 in order.
- Assert `reset`=0 during DATA of 0x55 → all outputs 0 immediately. Release, then send 0x2A → `dado`=0x2A, clean reception.
